pll_reconfig_seq: RTL and testbench

Sequencer that retunes the video/system PLL through the Avalon-MM management port of the PLL reconfiguration IP. It watches a requested clock profile (native vs. 60 Hz-adjusted, plus bootleg variants), filters it for stability, issues the mode, fractional-M and start writes with proper waitrequest handshaking, then waits for PLL lock. It sits in the emu top level on the 50 MHz management clock, between the OSD/status decode and `pll_cfg`.

---
 rtl/pll_reconfig_seq.sv | 203 ++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// -----------------------------------------------------------------------------
// pll_reconfig_seq
//
// Retunes the video/system PLL through the Avalon-MM management port of the
// PLL reconfiguration IP. A requested clock profile is filtered for stability.
// The sequencer then writes the mode, fractional-M and start registers, and
// waits for the PLL to report lock.
//
// Ports:
//   clk              management clock (50 MHz)
//   reset            synchronous, active-high
//   profile[1:0]     requested profile (asynchronous to clk)
//   locked           PLL lock (asynchronous, double-synchronised here)
//   cfg_waitrequest  management port waitrequest
//   cfg_write        management write strobe
//   cfg_address[5:0] management address
//   cfg_data[31:0]   management write data
//   busy             reconfiguration sequence in progress
//   done             one-cycle pulse on successful completion
//   error            sticky lock-timeout flag
//   active_profile   last profile written to the PLL
// -----------------------------------------------------------------------------
module pll_reconfig_seq #(
    parameter logic [31:0] FRAC0         = 32'd3639383488,
    parameter logic [31:0] FRAC1         = 32'd2977614927,
    parameter logic [31:0] FRAC2         = 32'd3639383488,
    parameter logic [31:0] FRAC3         = 32'd2977614927,
    parameter int          RESET_PROFILE = 0,
    parameter int          STABLE_CYCLES = 2,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          LOCK_TIMEOUT  = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  profile,
    input  logic        locked,
    input  logic        cfg_waitrequest,
    output logic        cfg_write,
    output logic [5:0]  cfg_address,
    output logic [31:0] cfg_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  active_profile
);

    localparam logic [3:0]   STABLE_N    = 4'(STABLE_CYCLES);
    localparam logic [23:0]  SETTLE_LAST = 24'(SETTLE_CYCLES - 1);
    localparam logic [23:0]  LOCK_LAST   = 24'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]   RESET_P     = 2'(RESET_PROFILE);
    localparam logic [127:0] FRAC_FLAT   = {FRAC3, FRAC2, FRAC1, FRAC0};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MODE   = 3'd1,
        FRAC   = 3'd2,
        START  = 3'd3,
        SETTLE = 3'd4,
        LOCK   = 3'd5
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  p_reg;
    logic [3:0]  stab_cnt_reg;
    logic [1:0]  lock_sync_reg;
    logic [23:0] cnt_reg;
    logic [1:0]  target_reg;
    logic [1:0]  active_reg;
    logic        error_reg;
    logic [5:0]  addr_reg;
    logic [31:0] data_reg;

    logic        req_valid;
    logic        load_target;
    logic        apply_profile;
    logic        set_error;
    logic        clr_error;
    logic        lock_ok;
    logic [31:0] frac_sel;

    assign req_valid = (stab_cnt_reg == STABLE_N) && (p_reg != active_reg);
    assign lock_ok   = lock_sync_reg[1];
    assign frac_sel  = FRAC_FLAT[{target_reg, 5'b00000} +: 32];

    // Next-state and strobe decode
    always_comb begin
        state_next    = state_reg;
        cfg_write     = 1'b0;
        done          = 1'b0;
        load_target   = 1'b0;
        apply_profile = 1'b0;
        set_error     = 1'b0;
        clr_error     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    load_target = 1'b1;
                    state_next  = MODE;
                end
            end
            MODE: begin
                cfg_write = 1'b1;
                if (!cfg_waitrequest) state_next = FRAC;
            end
            FRAC: begin
                cfg_write = 1'b1;
                if (!cfg_waitrequest) state_next = START;
            end
            START: begin
                cfg_write = 1'b1;
                if (!cfg_waitrequest) begin
                    apply_profile = 1'b1;
                    state_next    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_reg == SETTLE_LAST) state_next = LOCK;
            end
            LOCK: begin
                // Lock wins over a timeout landing on the same cycle.
                if (lock_ok && !cfg_waitrequest) begin
                    done       = 1'b1;
                    clr_error  = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg == LOCK_LAST) begin
                    set_error  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            p_reg         <= RESET_P;
            stab_cnt_reg  <= 4'd0;
            lock_sync_reg <= 2'b00;
            cnt_reg       <= 24'd0;
            target_reg    <= RESET_P;
            active_reg    <= RESET_P;
            error_reg     <= 1'b0;
            addr_reg      <= 6'd0;
            data_reg      <= 32'd0;
        end else begin
            state_reg     <= state_next;
            p_reg         <= profile;
            lock_sync_reg <= {lock_sync_reg[0], locked};

            // Stability filter: saturates at the threshold so a request that
            // stays stable while a sequence runs is still seen on return to IDLE.
            if (profile != p_reg) begin
                stab_cnt_reg <= 4'd0;
            end else if (stab_cnt_reg != STABLE_N) begin
                stab_cnt_reg <= stab_cnt_reg + 4'd1;
            end

            // Shared settle / lock-timeout counter, restarted on every state change.
            if (state_next != state_reg) begin
                cnt_reg <= 24'd0;
            end else if (state_reg == SETTLE || state_reg == LOCK) begin
                cnt_reg <= cnt_reg + 24'd1;
            end

            if (load_target)   target_reg <= p_reg;
            if (apply_profile) active_reg <= target_reg;

            if (set_error) begin
                error_reg <= 1'b1;
            end else if (clr_error) begin
                error_reg <= 1'b0;
            end

            // Address/data are loaded on entry to a write state and held
            // otherwise, so they stay stable across waitrequest stalls.
            if (state_next != state_reg) begin
                case (state_next)
                    MODE: begin
                        addr_reg <= 6'd0;
                        data_reg <= 32'd0;
                    end
                    FRAC: begin
                        addr_reg <= 6'd7;
                        data_reg <= frac_sel;
                    end
                    START: begin
                        addr_reg <= 6'd2;
                        data_reg <= 32'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cfg_address    = addr_reg;
    assign cfg_data       = data_reg;
    assign busy           = (state_reg != IDLE);
    assign error          = error_reg;
    assign active_profile = active_reg;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// -----------------------------------------------------------------------------
// Testbench for pll_reconfig_seq. It uses a table-driven cycle trace for the
// basic 0->1 retune. Hand-written sequences cover waitrequest stalls, glitch
// rejection, a change during LOCK, lock timeout and reset mid-sequence.
// -----------------------------------------------------------------------------
module tb_pll_reconfig_seq;

    localparam logic [31:0] F0 = 32'd3639383488;
    localparam logic [31:0] F1 = 32'd2977614927;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  profile = 2'd0;
    logic        locked = 1'b1;
    logic        cfg_waitrequest = 1'b0;
    logic        cfg_write;
    logic [5:0]  cfg_address;
    logic [31:0] cfg_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  active_profile;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pll_reconfig_seq #(
        .LOCK_TIMEOUT(100)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .profile        (profile),
        .locked         (locked),
        .cfg_waitrequest(cfg_waitrequest),
        .cfg_write      (cfg_write),
        .cfg_address    (cfg_address),
        .cfg_data       (cfg_data),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .active_profile (active_profile)
    );

    typedef struct {
        logic [1:0]  profile;
        logic        wreq;
        logic        lock;
        logic        exp_write;
        logic [5:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_busy;
        logic        exp_done;
        logic [1:0]  exp_active;
    } vec_t;

    vec_t vecs [26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_write(input logic [5:0] a, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cfg_write && cfg_address == a) begin
                found = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_done(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                found = 1'b1;
                return;
            end
            tick();
        end
    endtask

    initial begin
        bit found;
        int n_write;
        int n_busy;
        int n_acc;
        int n_done;

        // Cycle trace for 0->1: request seen in cycle 0, MODE/FRAC/START in
        // cycles 4/5/6, settle 7..22, done in 23, idle from 24.
        for (int c = 0; c < 26; c++) begin
            vecs[c].profile    = 2'd1;
            vecs[c].wreq       = 1'b0;
            vecs[c].lock       = 1'b1;
            vecs[c].exp_write  = (c >= 4 && c <= 6);
            vecs[c].exp_addr   = (c < 5) ? 6'd0 : (c == 5) ? 6'd7 : 6'd2;
            vecs[c].exp_data   = (c == 5) ? F1 : 32'd0;
            vecs[c].exp_busy   = (c >= 4 && c <= 23);
            vecs[c].exp_done   = (c == 23);
            vecs[c].exp_active = (c >= 7) ? 2'd1 : 2'd0;
        end

        // Reset state
        tick(); tick(); tick();
        chk("reset_write", cfg_write, 0);
        chk("reset_addr", cfg_address, 0);
        chk("reset_data", cfg_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_active", active_profile, 0);
        reset = 1'b0;

        // Idle hold with profile 0
        n_write = 0; n_busy = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cfg_write) n_write++;
            if (busy) n_busy++;
        end
        chk("idle_writes", n_write, 0);
        chk("idle_busy", n_busy, 0);
        chk("idle_active", active_profile, 0);

        // Table-driven 0->1 retune
        for (int c = 0; c < 26; c++) begin
            profile = vecs[c].profile;
            cfg_waitrequest = vecs[c].wreq;
            locked = vecs[c].lock;
            #1;
            chk($sformatf("v%0d_write", c), cfg_write, vecs[c].exp_write);
            chk($sformatf("v%0d_busy", c), busy, vecs[c].exp_busy);
            chk($sformatf("v%0d_done", c), done, vecs[c].exp_done);
            chk($sformatf("v%0d_active", c), active_profile, vecs[c].exp_active);
            if (vecs[c].exp_write) begin
                chk($sformatf("v%0d_addr", c), cfg_address, vecs[c].exp_addr);
                chk($sformatf("v%0d_data", c), cfg_data, vecs[c].exp_data);
            end
            @(posedge clk);
            #1;
        end

        // Waitrequest stall of 5 cycles during FRAC (1->0)
        profile = 2'd0;
        cfg_waitrequest = 1'b0;
        wait_write(6'd0, 20, found);
        chk("stall_mode_seen", found, 1);
        tick();
        n_write = 0; n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            cfg_waitrequest = (k < 5);
            #1;
            if (cfg_write && cfg_address == 6'd7 && cfg_data == F0) n_write++;
            if (cfg_write && !cfg_waitrequest && cfg_address == 6'd7) n_acc++;
            tick();
        end
        cfg_waitrequest = 1'b0;
        #1;
        chk("stall_frac_cycles", n_write, 6);
        chk("stall_frac_accepts", n_acc, 1);
        chk("stall_start_write", cfg_write, 1);
        chk("stall_start_addr", cfg_address, 2);
        wait_done(40, found);
        chk("stall_done_seen", found, 1);
        chk("stall_active", active_profile, 0);
        tick();

        // One-cycle glitch must be rejected
        profile = 2'd1;
        tick();
        profile = 2'd0;
        n_write = 0; n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cfg_write) n_write++;
            if (busy) n_busy++;
        end
        chk("glitch_writes", n_write, 0);
        chk("glitch_busy", n_busy, 0);

        // Profile change while waiting for lock
        locked = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        profile = 2'd1;
        wait_write(6'd2, 20, found);
        chk("lockchg_start_seen", found, 1);
        for (int i = 0; i < 17; i++) tick();
        chk("lockchg_in_lock_busy", busy, 1);
        chk("lockchg_in_lock_done", done, 0);
        profile = 2'd0;
        for (int i = 0; i < 5; i++) tick();
        locked = 1'b1;
        wait_done(20, found);
        chk("lockchg_first_done", found, 1);
        chk("lockchg_first_active", active_profile, 1);
        tick();
        wait_write(6'd7, 20, found);
        chk("lockchg_second_frac", found, 1);
        chk("lockchg_second_data", cfg_data, F0);
        wait_done(40, found);
        chk("lockchg_second_done", found, 1);
        chk("lockchg_second_active", active_profile, 0);
        tick();

        // Lock timeout (100 LOCK cycles)
        locked = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        profile = 2'd1;
        wait_write(6'd2, 20, found);
        chk("tmo_start_seen", found, 1);
        n_done = 0;
        for (int i = 1; i <= 117; i++) begin
            tick();
            if (done) n_done++;
            if (i == 116) begin
                chk("tmo_last_lock_busy", busy, 1);
                chk("tmo_last_lock_error", error, 0);
            end
            if (i == 117) begin
                chk("tmo_idle_busy", busy, 0);
                chk("tmo_error", error, 1);
            end
        end
        chk("tmo_no_done", n_done, 0);
        chk("tmo_active", active_profile, 1);

        // Reset during FRAC
        profile = 2'd0;
        wait_write(6'd7, 20, found);
        chk("rst_frac_seen", found, 1);
        reset = 1'b1;
        tick();
        chk("rst_write", cfg_write, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", cfg_address, 0);
        chk("rst_data", cfg_data, 0);
        chk("rst_active", active_profile, 0);
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
